// File: rtl/irq_ctrl_if.sv
// Host IO-port bus for irq_ctrl: a 4-register window selected by sel, written
// on sel & wr, with combinational read data.
interface irq_ctrl_if;
  logic       sel;
  logic       wr;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output sel, output wr, output addr, output din, input dout);
  modport slave  (input sel, input wr, input addr, input din, output dout);
endinterface

// File: rtl/irq_ctrl.sv
// Four-source Mode 2 interrupt controller: edge-triggered PENDING, MASK, fixed priority.
// Define IRQ_CTRL_SYNC_EN to pass each src bit through a 2-flop synchroniser first.
module irq_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] src,
  input  logic       inta,
  output logic       int_n,
  output logic [7:0] vector,
  irq_ctrl_if.slave  bus
);

`ifdef IRQ_CTRL_SYNC_EN
  localparam logic [1:0] ARM_CYC = 2'd3;
`else
  localparam logic [1:0] ARM_CYC = 2'd1;
`endif

  logic [3:0] r_mask;
  logic [3:0] r_pending;
  logic [1:0] r_base;
  logic [7:0] r_vector;
  logic       r_int_n;
  logic [3:0] r_src_d;
  logic       r_inta_d;
  logic [1:0] r_arm_cnt;

  logic [3:0] w_src;
  logic [3:0] w_rise;
  logic       w_armed;
  logic       w_ack;
  logic       w_wr;
  logic [3:0] w_mp;
  logic       w_valid;
  logic [1:0] w_idx;
  logic [3:0] w_clr;
  logic [3:0] w_pend_nxt;
  logic       w_unused_din;

`ifdef IRQ_CTRL_SYNC_EN
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 4'h0;
      r_sync2 <= 4'h0;
    end else begin
      r_sync1 <= src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = src;
`endif

  // Edges are ignored until the detector has seen one settled sample after
  // reset, so a source (or inta) held high through release is not an event.
  assign w_armed = (r_arm_cnt == ARM_CYC);
  assign w_rise  = w_armed ? (w_src & ~r_src_d) : 4'h0;
  assign w_ack   = inta & ~r_inta_d & (r_arm_cnt != 2'd0);
  assign w_wr    = bus.sel & bus.wr;
  assign w_mp    = r_pending & r_mask;
  assign w_valid = |w_mp;
  assign w_unused_din = ^bus.din[5:4];

  always_comb begin
    w_idx = 2'd0;
    if (w_mp[0])      w_idx = 2'd0;
    else if (w_mp[1]) w_idx = 2'd1;
    else if (w_mp[2]) w_idx = 2'd2;
    else if (w_mp[3]) w_idx = 2'd3;
  end

  // A new rising edge wins over any clear landing on the same bit.
  always_comb begin
    w_clr = 4'h0;
    if (w_ack && w_valid)
      w_clr[w_idx] = 1'b1;
    if (w_wr && (bus.addr == 2'd1))
      w_clr = w_clr | bus.din[3:0];
    w_pend_nxt = (r_pending & ~w_clr) | w_rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src_d   <= 4'h0;
      r_inta_d  <= 1'b0;
      r_arm_cnt <= 2'd0;
    end else begin
      r_src_d  <= w_src;
      r_inta_d <= inta;
      if (!w_armed)
        r_arm_cnt <= r_arm_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= 4'h0;
      r_base <= 2'b00;
    end else if (w_wr) begin
      if (bus.addr == 2'd0) r_mask <= bus.din[3:0];
      if (bus.addr == 2'd2) r_base <= bus.din[7:6];
    end
  end

  // The acknowledge samples the current MASK/BASE, so a same-cycle write
  // only takes effect from the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= 4'h0;
      r_vector  <= 8'h00;
      r_int_n   <= 1'b1;
    end else begin
      r_pending <= w_pend_nxt;
      if (w_ack)
        r_vector <= w_valid ? {r_base, w_idx, 4'h0} : {r_base, 6'b111110};
      r_int_n <= w_ack ? 1'b1 : ~w_valid;
    end
  end

  always_comb begin
    bus.dout = 8'h00;
    case (bus.addr)
      2'd0: bus.dout = {4'h0, r_mask};
      2'd1: bus.dout = {4'h0, r_pending};
      2'd2: bus.dout = {r_base, 6'b000000};
      2'd3: bus.dout = r_vector;
      default: bus.dout = 8'h00;
    endcase
  end

  assign vector = r_vector;
  assign int_n  = r_int_n;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed-vector bench for irq_ctrl with hand-computed expectations.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] src;
  logic       inta;
  logic       int_n;
  logic [7:0] vector;
  int         n_tests = 0;
  int         n_fail  = 0;

  irq_ctrl_if bus_if ();

  irq_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .src    (src),
    .inta   (inta),
    .int_n  (int_n),
    .vector (vector),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    bus_if.addr = a;
    #1;
    check(tag, bus_if.dout, exp);
  endtask

  task automatic wreg(input logic [1:0] a, input logic [7:0] d);
    bus_if.sel  = 1'b1;
    bus_if.wr   = 1'b1;
    bus_if.addr = a;
    bus_if.din  = d;
    cyc(1);
    bus_if.sel = 1'b0;
    bus_if.wr  = 1'b0;
  endtask

  task automatic pulse_src(input logic [3:0] s);
    src = s;
    cyc(4);
    src = 4'h0;
    cyc(4);
  endtask

  initial begin
    reset = 1'b1;
    src = 4'hF;
    inta = 1'b0;
    bus_if.sel = 1'b0;
    bus_if.wr = 1'b0;
    bus_if.addr = 2'd0;
    bus_if.din = 8'h00;
    cyc(3);
    check("rst_int_n", {7'd0, int_n}, 8'h01);
    check("rst_vector", vector, 8'h00);
    chk_reg("rst_mask", 2'd0, 8'h00);
    reset = 1'b0;
    cyc(6);
    chk_reg("src_high_thru_release", 2'd1, 8'h00);
    src = 4'h0;
    cyc(5);

    // Latency from src rising to PENDING, then int_n one cycle later
    wreg(2'd0, 8'h01);
    src = 4'h1;
    cyc(LAT);
    chk_reg("lat_pending", 2'd1, 8'h01);
    check("lat_int_n_still_hi", {7'd0, int_n}, 8'h01);
    cyc(1);
    check("lat_int_n_lo", {7'd0, int_n}, 8'h00);
    src = 4'h0;
    wreg(2'd1, 8'h01);
    chk_reg("w1c_pending", 2'd1, 8'h00);
    cyc(1);
    check("w1c_int_n_hi", {7'd0, int_n}, 8'h01);

    // Scenario 1
    wreg(2'd0, 8'h04);
    pulse_src(4'h4);
    chk_reg("s1_pending", 2'd1, 8'h04);
    check("s1_int_n_lo", {7'd0, int_n}, 8'h00);
    inta = 1'b1;
    cyc(3);
    inta = 1'b0;
    cyc(1);
    check("s1_vector", vector, 8'h20);
    chk_reg("s1_pending_clr", 2'd1, 8'h00);
    check("s1_int_n_hi", {7'd0, int_n}, 8'h01);

    // Scenario 2
    wreg(2'd0, 8'h0F);
    pulse_src(4'h9);
    chk_reg("s2_pending", 2'd1, 8'h09);
    inta = 1'b1;
    cyc(1);
    check("s2_vec0", vector, 8'h00);
    check("s2_ack_int_n_hi", {7'd0, int_n}, 8'h01);
    chk_reg("s2_pending_after0", 2'd1, 8'h08);
    cyc(1);
    check("s2_reassert", {7'd0, int_n}, 8'h00);
    cyc(1);
    check("s2_held_inta_no_ack", vector, 8'h00);
    inta = 1'b0;
    cyc(1);
    inta = 1'b1;
    cyc(1);
    check("s2_vec3", vector, 8'h30);
    inta = 1'b0;
    cyc(3);
    check("s2_int_n_stays_hi", {7'd0, int_n}, 8'h01);
    chk_reg("s2_pending_empty", 2'd1, 8'h00);

    // Scenario 3
    wreg(2'd2, 8'hC0);
    wreg(2'd0, 8'hF2);
    chk_reg("s3_base", 2'd2, 8'hC0);
    chk_reg("s3_mask_unused0", 2'd0, 8'h02);
    pulse_src(4'h2);
    inta = 1'b1;
    cyc(1);
    inta = 1'b0;
    check("s3_vector", vector, 8'hD0);
    cyc(1);
    chk_reg("s3_last", 2'd3, 8'hD0);
    wreg(2'd3, 8'h55);
    chk_reg("s3_last_ro", 2'd3, 8'hD0);
    wreg(2'd2, 8'h00);

    // Scenario 4
    wreg(2'd0, 8'h00);
    pulse_src(4'h1);
    chk_reg("s4_pending", 2'd1, 8'h01);
    check("s4_int_n_masked", {7'd0, int_n}, 8'h01);
    wreg(2'd0, 8'h01);
    check("s4_int_n_write_cycle", {7'd0, int_n}, 8'h01);
    cyc(1);
    check("s4_int_n_after_mask", {7'd0, int_n}, 8'h00);
    wreg(2'd1, 8'h01);
    chk_reg("s4_pending_w1c", 2'd1, 8'h00);
    cyc(1);
    check("s4_int_n_cleared", {7'd0, int_n}, 8'h01);

    // Scenario 5: spurious acknowledge, then ack racing a MASK write
    inta = 1'b1;
    cyc(1);
    inta = 1'b0;
    check("s5_vector_spur", vector, 8'h3E);
    chk_reg("s5_pending", 2'd1, 8'h00);
    check("s5_int_n", {7'd0, int_n}, 8'h01);
    cyc(1);
    wreg(2'd0, 8'h00);
    wreg(2'd2, 8'h40);
    pulse_src(4'h2);
    bus_if.sel = 1'b1;
    bus_if.wr = 1'b1;
    bus_if.addr = 2'd0;
    bus_if.din = 8'h02;
    inta = 1'b1;
    cyc(1);
    bus_if.sel = 1'b0;
    bus_if.wr = 1'b0;
    inta = 1'b0;
    check("s5_old_mask_vector", vector, 8'h7E);
    chk_reg("s5_spur_keeps_pending", 2'd1, 8'h02);
    cyc(1);
    check("s5_new_mask_int_n", {7'd0, int_n}, 8'h00);
    wreg(2'd1, 8'h0F);
    wreg(2'd2, 8'h00);
    cyc(1);

    // Scenario 6: set and acknowledge of the same bit in one cycle
    wreg(2'd0, 8'h04);
    pulse_src(4'h4);
    check("s6_int_n_lo", {7'd0, int_n}, 8'h00);
    src = 4'h4;
    cyc(LAT - 1);
    inta = 1'b1;
    cyc(1);
    check("s6_vector", vector, 8'h20);
    chk_reg("s6_pending_kept", 2'd1, 8'h04);
    check("s6_int_n_hi_one", {7'd0, int_n}, 8'h01);
    cyc(1);
    check("s6_int_n_reassert", {7'd0, int_n}, 8'h00);
    reset = 1'b1;
    #1;
    check("s6_rst_int_n", {7'd0, int_n}, 8'h01);
    check("s6_rst_vector", vector, 8'h00);
    cyc(2);
    inta = 1'b0;
    src = 4'h0;
    reset = 1'b0;
    cyc(2);
    chk_reg("s6_mask", 2'd0, 8'h00);
    chk_reg("s6_pending", 2'd1, 8'h00);
    chk_reg("s6_base", 2'd2, 8'h00);
    cyc(1);
    chk_reg("s6_last", 2'd3, 8'h00);
    check("s6_int_n_after", {7'd0, int_n}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, and no other clocks or resets.
REQ-002 clk  input  1  CPU bus clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 src  input  4  interrupt request sources; src[0] is the 50 Hz tick, src[2] is video vsync, the others are spare; any clock domain.
REQ-005 sel  input  1  IO port select, decoded by the host for the 4-port window.
REQ-006 wr  input  1  write strobe, valid with sel.
REQ-007 addr  input  2  register index.
REQ-008 din  input  8  write data.
REQ-009 dout  output  8  read data for the indexed register; combinational from registers.
REQ-010 inta  input  1  CPU interrupt acknowledge, asserted while the IORQ and M1 strobes are both active.
REQ-011 int_n  output  1  active-low interrupt request to the CPU; registered.
REQ-012 vector  output  8  Mode 2 vector byte; registered; held stable between acknowledges.

Function
REQ-013 The block SHALL hold these registers: MASK, addr 0, R/W, bits 3:0; PENDING, addr 1, read, write-1-to-clear, bits 3:0; BASE, addr 2, R/W, bits 7:6; LAST, addr 3, read-only copy of vector.
REQ-014 Unused register bits SHALL read 0, and a write to LAST SHALL be ignored.
REQ-015 PENDING[i] SHALL set on a rising edge of src[i], detected from synchronised samples.
REQ-016 The set of a PENDING bit SHALL not depend on MASK.
REQ-017 int_n SHALL be 0 in the cycle after (PENDING & MASK) != 0, and 1 in the cycle after it becomes 0.
REQ-018 Priority SHALL be fixed: index 0 highest, index 3 lowest.
REQ-019 Acknowledge SHALL be taken on the first cycle of inta high (a rising edge of inta); further cycles of the same inta pulse SHALL have no effect.
REQ-020 On acknowledge, the block SHALL select the highest-priority bit of PENDING & MASK, set vector = {BASE[7:6], idx[1:0], 4'h0} on the next edge, and clear that PENDING bit.
REQ-021 With BASE = 0, index 2 SHALL give vector 0x20 and index 3 SHALL give 0x30.
REQ-022 A spurious acknowledge (no masked-pending bit) SHALL load vector = {BASE[7:6], 6'b111110}.
REQ-023 A spurious acknowledge SHALL leave PENDING unchanged.
REQ-024 When an acknowledge is registered, int_n SHALL go to 1 for one cycle.
REQ-025 After that one cycle, int_n SHALL re-evaluate per REQ-017, so other masked-pending bits re-assert the request.
REQ-026 Simultaneous set and clear of the same PENDING bit SHALL leave the bit set; clear sources are acknowledge or write-1-to-clear.
REQ-027 A MASK write SHALL affect int_n from the cycle after the write.
REQ-028 A MASK write in the same cycle as an acknowledge edge SHALL leave the acknowledge to use the old MASK.
REQ-029 Writes SHALL be taken on every cycle where sel and wr are both high; the host guarantees a single-cycle-qualified strobe.
REQ-030 A src pulse shorter than two clk periods may be lost; no latching of glitches SHALL be required.

Reset
REQ-031 Reset SHALL clear MASK to 0x0, PENDING to 0x0, BASE to 0x0 and all synchroniser and edge flops to 0.
REQ-032 Reset SHALL set vector to 0x00 and int_n to 1.
REQ-033 A src held high through the release of reset SHALL not produce a pending edge.
REQ-034 Reset asserted mid-acknowledge SHALL abort the acknowledge, and the state after reset release SHALL be exactly the reset state.

Configuration
REQ-035 With macro IRQ_CTRL_SYNC_EN defined, each src bit SHALL pass through a 2-flop synchroniser before edge detection.
REQ-036 With IRQ_CTRL_SYNC_EN defined, PENDING SHALL set 3 clk edges after src is first sampled high.
REQ-037 With IRQ_CTRL_SYNC_EN undefined, src SHALL feed edge detection directly, for sources already in the clk domain.
REQ-038 With IRQ_CTRL_SYNC_EN undefined, PENDING SHALL set on the 1st edge after src is first sampled high.
REQ-039 All other behaviour SHALL be identical with and without IRQ_CTRL_SYNC_EN.

Verification
REQ-040 Scenario 1: MASK = 0x4, pulse src[2] for 4 cycles → PENDING = 0x4, int_n low; pulse inta → vector = 0x20, PENDING = 0x0, int_n high.
REQ-041 Scenario 2: MASK = 0xF, src[3] and src[0] rise in the same cycle → first inta gives vector 0x00, second inta gives 0x30, then int_n stays high.
REQ-042 Scenario 3: BASE = 0xC0, MASK = 0x2, pulse src[1], then inta → vector = 0xD0; reading addr 3 returns 0xD0.
REQ-043 Scenario 4: MASK = 0x0, pulse src[0] → PENDING = 0x1, int_n stays high; write MASK = 0x1 → int_n low the cycle after; write 0x1 to addr 1 → PENDING = 0, int_n high.
REQ-044 Scenario 5: PENDING = 0 and inta pulsed → vector = 0x3E, PENDING unchanged, int_n stays high.
REQ-045 Scenario 6: src[2] rises in the cycle its PENDING bit is acknowledged → PENDING[2] remains 1 and int_n re-asserts after the one-cycle high; assert reset mid-sequence → all registers return to their reset values.
